// File: rtl/serial_pkg.sv
// Shared types and width helpers for the bit serializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_period_divider.sv
// Bit-period timer: marks the first and last clock of every DIV-clock bit slot.
// Latency: ticks are combinational from the counter; counter advances each clock while run=1.
// Backpressure: none; restart or run=0 parks the counter at the start of a slot.
module bit_period_divider
   import serial_pkg::*;
#(
   parameter int DIV = 1
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic restart,
   output logic tick_first,
   output logic tick_last
);

   generate
      if (DIV == 1) begin : g_pass
         // Every clock is both the first and last of its own bit slot.
         logic w_unused;
         assign w_unused   = &{1'b0, clk, reset_n, restart};
         assign tick_first = run;
         assign tick_last  = run;
      end else begin : g_cnt
         localparam int CW = cnt_w(DIV);
         localparam logic [CW-1:0] LAST = CW'(DIV - 1);

         logic [CW-1:0] r_cnt;

         // Count 0..DIV-1 within the slot; hold at 0 when idle or restarting.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt <= '0;
            end else if (!run || restart || (r_cnt == LAST)) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign tick_first = run && (r_cnt == '0);
         assign tick_last  = run && (r_cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out: streams WIDTH-bit words one bit per DIV clocks on ser_out.
// Latency: word accepted at edge N shows its first bit from edge N+1; back-to-back words have no gap.
// Backpressure: in_ready is high only when idle or on the last clock of the last bit of a word.
module piso_bit_serializer
   import serial_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   DIV        = 1,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             bit_strobe,
   output logic             busy,
   output logic             frame_done
);

   localparam int BW = cnt_w(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_bit_cnt;
   logic             r_ser;

   logic             w_run;
   logic             w_tick_first;
   logic             w_tick_last;
   logic             w_bit_end;
   logic             w_last;
   logic             w_ready;
   logic             w_load;
   logic             w_head_in;
   logic             w_head_reg;
   logic [WIDTH-1:0] w_shift_in;
   logic [WIDTH-1:0] w_shift_reg;

   assign w_run = (r_state == SHIFT);

   bit_period_divider #(
      .DIV (DIV)
   ) u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (w_run),
      .restart    (w_load),
      .tick_first (w_tick_first),
      .tick_last  (w_tick_last)
   );

   // Handshake and end-of-word decode; ready never looks at in_valid.
   always_comb begin
      w_bit_end = w_run && w_tick_last;
      w_last    = w_bit_end && (r_bit_cnt == LAST_BIT);
      w_ready   = (r_state == IDLE) || w_last;
      w_load    = in_valid && w_ready;
   end

   // Pick the outgoing bit and the remaining bits, for a fresh word and for the held word.
   always_comb begin
      if (MSB_FIRST) begin
         w_head_in   = in_data[WIDTH-1];
         w_shift_in  = in_data << 1;
         w_head_reg  = r_shift[WIDTH-1];
         w_shift_reg = r_shift << 1;
      end else begin
         w_head_in   = in_data[0];
         w_shift_in  = in_data >> 1;
         w_head_reg  = r_shift[0];
         w_shift_reg = r_shift >> 1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: leave IDLE on a word, drop back only when a word ends with nothing queued.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = SHIFT;
         SHIFT:   if (w_last && !in_valid) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: load on transfer, advance one bit at each slot end, park at idle level after the word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_ser     <= IDLE_LEVEL;
      end else if (w_load) begin
         r_shift   <= w_shift_in;
         r_bit_cnt <= '0;
         r_ser     <= w_head_in;
      end else if (w_last) begin
         r_bit_cnt <= '0;
         r_ser     <= IDLE_LEVEL;
      end else if (w_bit_end) begin
         r_shift   <= w_shift_reg;
         r_bit_cnt <= r_bit_cnt + 1'b1;
         r_ser     <= w_head_reg;
      end
   end

   assign in_ready   = w_ready;
   assign ser_out    = r_ser;
   assign bit_strobe = w_run && w_tick_first;
   assign busy       = w_run;
   assign frame_done = w_last;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three instances (DIV=1 MSB-first, DIV=3 MSB-first, DIV=1 LSB-first).
// Latency: n/a.
// Backpressure: n/a.
module tb_piso_bit_serializer;

   localparam int NL = 3;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid   [NL];
   logic [W-1:0] in_data    [NL];
   logic         in_ready   [NL];
   logic         ser_out    [NL];
   logic         bit_strobe [NL];
   logic         busy       [NL];
   logic         frame_done [NL];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   piso_bit_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
      .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .ser_out(ser_out[0]), .bit_strobe(bit_strobe[0]),
      .busy(busy[0]), .frame_done(frame_done[0]));

   piso_bit_serializer #(.WIDTH(W), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .ser_out(ser_out[1]), .bit_strobe(bit_strobe[1]),
      .busy(busy[1]), .frame_done(frame_done[1]));

   piso_bit_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_c (
      .clk(clk), .reset_n(reset_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .ser_out(ser_out[2]), .bit_strobe(bit_strobe[2]),
      .busy(busy[2]), .frame_done(frame_done[2]));

   function automatic int div_of(input int ln);
      return (ln == 1) ? 3 : 1;
   endfunction

   function automatic bit msb_of(input int ln);
      return (ln != 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: position within the current word ----------------
   logic         m_act  [NL];
   int           m_pos  [NL];
   logic [W-1:0] m_word [NL];

   int   md;
   logic e_busy, e_fd, e_strb, e_ser, e_rdy, bad;

   always @(negedge clk) begin
      for (int ln = 0; ln < NL; ln++) begin
         if (!reset_n) begin
            m_act[ln] = 1'b0;
            m_pos[ln] = 0;
         end
         md     = div_of(ln);
         e_busy = m_act[ln];
         e_fd   = m_act[ln] && (m_pos[ln] == W * md - 1);
         e_strb = m_act[ln] && ((m_pos[ln] % md) == 0);
         e_ser  = !m_act[ln] ? 1'b0 :
                  msb_of(ln) ? m_word[ln][W - 1 - m_pos[ln] / md] : m_word[ln][m_pos[ln] / md];
         e_rdy  = !m_act[ln] || e_fd;
         bad = (ser_out[ln] !== e_ser) || (bit_strobe[ln] !== e_strb) ||
               (busy[ln] !== e_busy) || (frame_done[ln] !== e_fd) ||
               (reset_n && (in_ready[ln] !== e_rdy));
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL model lane%0d t=%0t got/exp: ser %b/%b strobe %b/%b busy %b/%b done %b/%b ready %b/%b",
                     ln, $time, ser_out[ln], e_ser, bit_strobe[ln], e_strb, busy[ln], e_busy,
                     frame_done[ln], e_fd, in_ready[ln], e_rdy);
         end
         if (reset_n) begin
            if (in_valid[ln] && e_rdy) begin
               m_act[ln]  = 1'b1;
               m_word[ln] = in_data[ln];
               m_pos[ln]  = 0;
            end else if (m_act[ln]) begin
               if (e_fd) m_act[ln] = 1'b0;
               else      m_pos[ln] = m_pos[ln] + 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic present(input int ln, input logic [W-1:0] d);
      @(posedge clk) #1;
      in_valid[ln] = 1'b1;
      in_data[ln]  = d;
   endtask

   // Returns just after the edge where the presented word transfers.
   task automatic accept(input int ln);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready[ln]) ok = 1'b1;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk) #1;
   endtask

   task automatic send1(input int ln, input logic [W-1:0] d);
      present(ln, d);
      accept(ln);
      in_valid[ln] = 1'b0;
      in_data[ln]  = W'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  bits;
      logic [15:0] stream;
      logic        all;
      int          cnt, at, hits, last;
      logic        s [16];

      for (int ln = 0; ln < NL; ln++) begin
         in_valid[ln] = 1'b0;
         in_data[ln]  = '0;
      end

      // reset state
      repeat (3) @(negedge clk);
      for (int ln = 0; ln < NL; ln++) begin
         check("rst_ser", ser_out[ln], 0);
         check("rst_busy", busy[ln], 0);
         check("rst_strobe", bit_strobe[ln], 0);
         check("rst_done", frame_done[ln], 0);
      end
      @(posedge clk) #1 reset_n = 1'b1;
      @(negedge clk);
      for (int ln = 0; ln < NL; ln++) check("rdy_after_rst", in_ready[ln], 1);

      // single word A5, DIV=1, MSB first
      send1(0, 8'hA5);
      bits = '0; all = 1'b1; cnt = 0; at = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bits = {bits[6:0], ser_out[0]};
         all  = all & bit_strobe[0];
         if (frame_done[0]) begin cnt++; at = i; end
      end
      check("a5_bits", bits, 8'hA5);
      check("a5_strobe_all", all, 1);
      check("a5_done_count", cnt, 1);
      check("a5_done_at", at, 7);
      @(negedge clk);
      check("a5_idle_ser", ser_out[0], 0);
      check("a5_idle_ready", in_ready[0], 1);

      // back-to-back 05 then A0 with in_valid held
      present(0, 8'h05);
      accept(0);
      in_data[0] = 8'hA0;
      stream = '0; all = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         stream = {stream[14:0], ser_out[0]};
         all    = all & busy[0];
         if (i == 7) begin
            check("b2b_ready_at_boundary", in_ready[0], 1);
            @(posedge clk) #1;
            in_valid[0] = 1'b0;
            in_data[0]  = W'($urandom);
         end
      end
      check("b2b_stream", stream, 16'h05A0);
      check("b2b_busy", all, 1);
      for (int i = 0; i < 16; i++) s[i] = stream[15 - i];
      hits = 0; last = -1;
      for (int i = 2; i < 16; i++)
         if (s[i-2] && !s[i-1] && s[i]) begin hits++; last = i; end
      check("b2b_101_hits", hits, 2);
      check("b2b_101_last", last, 10);

      // DIV=3, C3
      send1(1, 8'hC3);
      bits = '0; cnt = 0; at = -1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (bit_strobe[1]) begin cnt++; bits = {bits[6:0], ser_out[1]}; end
         if (frame_done[1]) at = c;
      end
      check("div3_strobes", cnt, 8);
      check("div3_bits", bits, 8'hC3);
      check("div3_done_cycle", at, 24);
      @(negedge clk);
      check("div3_idle_busy", busy[1], 0);

      // LSB first, 01
      send1(2, 8'h01);
      bits = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bits = {bits[6:0], ser_out[2]};
      end
      check("lsb_bits", bits, 8'h80);

      // FF presented mid-word while busy
      send1(0, 8'h3C);
      stream = '0; cnt = 0; at = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         stream = {stream[14:0], ser_out[0]};
         if (i >= 3 && i < 7 && in_ready[0]) cnt++;
         if (i >= 3 && in_valid[0] && in_ready[0]) begin
            at = i;
            @(posedge clk) #1;
            in_valid[0] = 1'b0;
            in_data[0]  = W'($urandom);
         end
         if (i == 2) begin
            @(posedge clk) #1;
            in_valid[0] = 1'b1;
            in_data[0]  = 8'hFF;
         end
      end
      check("mid_ready_early", cnt, 0);
      check("mid_taken_at", at, 7);
      check("mid_stream", stream, 16'h3CFF);

      // reset in the middle of AA, then 55
      send1(0, 8'hAA);
      repeat (4) @(negedge clk);
      @(posedge clk) #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_ser", ser_out[0], 0);
      check("rst_mid_busy", busy[0], 0);
      check("rst_mid_done", frame_done[0], 0);
      repeat (2) @(negedge clk);
      @(posedge clk) #1 reset_n = 1'b1;
      send1(0, 8'h55);
      bits = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bits = {bits[6:0], ser_out[0]};
      end
      check("post_rst_bits", bits, 8'h55);

      // randomized traffic on all lanes, checked by the model every cycle
      repeat (1500) begin
         @(posedge clk) #1;
         for (int ln = 0; ln < NL; ln++) begin
            in_valid[ln] = ($urandom_range(0, 3) != 0);
            in_data[ln]  = W'($urandom);
         end
      end
      @(posedge clk) #1;
      for (int ln = 0; ln < NL; ln++) in_valid[ln] = 1'b0;
      repeat (40) @(negedge clk);
      for (int ln = 0; ln < NL; ln++) check("drain_idle", busy[ln], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit at a time on ser_out.
- ser_out drives the detector x input, and bit_strobe qualifies each new bit.
- Back-to-back words stream with no idle gap, so patterns that span word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: word width in bits; must be >= 2.
- DIV, 1: clock cycles each bit is held on ser_out; must be >= 1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_LEVEL, 0: ser_out value while no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_out  output  1  serial bit stream (registered).
- bit_strobe  output  1  high on the first clock of each new bit.
- busy  output  1  a word is currently being shifted.
- frame_done  output  1  one-cycle pulse on the final clock of a word's last bit.

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0, and on leaving reset:
  - state=IDLE, shift register cleared, bit and divider counters 0.
  - ser_out=IDLE_LEVEL, bit_strobe=0, busy=0, frame_done=0.
  - in_ready=1 after reset deasserts.
- Two-state FSM:
  - IDLE: in_ready=1. If in_valid=1, the word is accepted at that edge and the FSM moves to SHIFT.
  - SHIFT: shift register outputs one bit per DIV clocks.
- Handshake:
  - Transfer occurs only on a clock edge where in_valid && in_ready.
  - in_ready is combinational from state and counters only; it never depends on in_valid.
  - in_data is sampled only at the transfer edge; changes at any other time are ignored.
- Latency: a word accepted at edge N shows its first bit on ser_out from edge N+1, with bit_strobe=1 in that cycle.
- Bit timing:
  - A clog2(DIV)-bit divider counter runs 0..DIV-1 for each bit.
  - bit_strobe=1 when the counter is 0 and the FSM is in SHIFT.
  - With DIV=1, bit_strobe stays high for the whole word.
- Ordering:
  - MSB_FIRST=1 sends in_data[WIDTH-1] first, down to in_data[0].
  - MSB_FIRST=0 reverses the order.
- Last-bit cycle: when the bit counter is WIDTH-1 and the divider is DIV-1:
  - frame_done=1 and in_ready=1.
  - If in_valid=1, the new word loads at that edge and its first bit follows with no gap; the FSM stays in SHIFT.
  - Otherwise the FSM returns to IDLE and ser_out=IDLE_LEVEL from the next cycle.
- busy=1 exactly when state=SHIFT.
- in_valid held high while in_ready=0: no transfer occurs, and the word is taken at the next ready cycle.
- Reset mid-word: the word is discarded, with no frame_done pulse and no partial resume.
- Counter widths: bit counter is clog2(WIDTH) bits and wraps only via reload; there is no free-running overflow.

Decomposition:
- Shared package serial_pkg holds:
  - state enum {IDLE, SHIFT}.
  - localparam helpers for counter widths (clog2 of WIDTH and DIV).
  - IDLE_LEVEL default.
- One sub-module, bit_period_divider: parameter DIV; inputs clk, reset_n, run, restart; outputs tick_first and tick_last.
  - With DIV=1 it reduces to tick_first = tick_last = run.

Test Plan:
- WIDTH=8, DIV=1, MSB_FIRST=1; send 8'hA5 once:
  - ser_out is 1,0,1,0,0,1,0,1 on cycles N+1..N+8.
  - bit_strobe is high for all 8 cycles; frame_done pulses at N+8.
  - ser_out=0 and in_ready=1 from N+9.
- Back-to-back 8'h05 then 8'hA0 with in_valid held:
  - 16 contiguous bits 00000101_10100000 with no idle cycle; busy stays 1.
  - A downstream 101 detector sees its hits at the word-boundary bits.
- DIV=3; send 8'hC3:
  - Each bit is held 3 cycles and bit_strobe is high once per 3 cycles.
  - frame_done pulses on cycle 24 after acceptance.
- MSB_FIRST=0; send 8'h01: ser_out is 1,0,0,0,0,0,0,0.
- in_valid=1 with 8'hFF asserted mid-word while busy:
  - in_ready=0, and the word is not taken until the last-bit cycle.
  - Stream continuity holds and no bit is lost or duplicated.
- reset_n pulled low at bit 4 of 8'hAA:
  - ser_out=IDLE_LEVEL and busy=0 immediately, with no frame_done.
  - After release, 8'h55 serializes correctly from bit 0.
